// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// States, opcode classes, ALU command fields and ALU control codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU command decode: control code, flag writes,
// flag-only marker and illegal-instruction detection.
module alu_decoder
    import mc_pkg::*;
#(
    parameter int ALU_W = 2
) (
    input  logic [1:0]       i_op,
    input  logic [5:0]       i_funct,
    output logic [ALU_W-1:0] o_alu_control,
    output logic [1:0]       o_flag_w,
    output logic             o_no_write,
    output logic             o_illegal
);

    logic [2:0] w_alu;
    logic       w_known;
    logic       w_arith;
    logic       w_fs;

    always_comb begin
        w_alu      = ALU_ADD;
        w_known    = 1'b1;
        w_arith    = 1'b0;
        o_no_write = 1'b0;
        case (i_funct[4:1])
            CMD_ADD: begin
                w_alu   = ALU_ADD;
                w_arith = 1'b1;
            end
            CMD_SUB: begin
                w_alu   = ALU_SUB;
                w_arith = 1'b1;
            end
            CMD_AND: w_alu = ALU_AND;
            CMD_ORR: w_alu = ALU_ORR;
            CMD_CMP: begin
                w_alu      = ALU_SUB;
                w_arith    = 1'b1;
                o_no_write = 1'b1;
            end
            CMD_TST: begin
                w_alu      = ALU_AND;
                o_no_write = 1'b1;
            end
            CMD_EOR: begin
                // Narrow ALUs have no XOR path, so EOR is undecodable
                if (ALU_W >= 3) w_alu = ALU_EOR;
                else            w_known = 1'b0;
            end
            default: w_known = 1'b0;
        endcase
        w_fs      = i_funct[0] | o_no_write;
        o_flag_w  = {w_fs, w_fs & w_arith};
        o_illegal = (i_op == OP_BAD)
                  | ((i_op == OP_DP) & ~w_known);
    end

    assign o_alu_control = w_alu[ALU_W-1:0];

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: registered FSM sequencing
// fetch/decode/execute/memory/writeback with a memory ready stall.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALU_W   = 2,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic               cond_ex,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               adr_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic               reg_w,
    output logic               mem_w,
    output logic               mem_req,
    output logic [ALU_W-1:0]   alu_control,
    output logic [1:0]         flag_w,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_t     r_state;
    logic [1:0] r_op;
    logic [5:0] r_funct;
    logic [3:0] r_rd;
    logic       r_cond;

    logic             w_dec;
    logic [1:0]       w_op;
    logic [5:0]       w_funct;
    logic [ALU_W-1:0] w_alu;
    logic [1:0]       w_flag;
    logic             w_nowr;
    logic             w_ill;
    logic             w_rd_pc;

    // DECODE judges the live instruction; later states use the latched copy
    assign w_dec   = (r_state == S_DECODE);
    assign w_op    = w_dec ? op : r_op;
    assign w_funct = w_dec ? funct : r_funct;
    assign w_rd_pc = (r_rd == 4'd15);

    alu_decoder #(
        .ALU_W(ALU_W)
    ) u_alu_dec (
        .i_op          (w_op),
        .i_funct       (w_funct),
        .o_alu_control (w_alu),
        .o_flag_w      (w_flag),
        .o_no_write    (w_nowr),
        .o_illegal     (w_ill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_funct <= '0;
            r_rd    <= '0;
            r_cond  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_op    <= op;
                    r_funct <= funct;
                    r_rd    <= rd;
                    r_cond  <= cond_ex;
                    if (w_ill)              r_state <= S_FETCH;
                    else if (op == OP_MEM)  r_state <= S_MEMADR;
                    else if (op == OP_BR)   r_state <= S_BRANCH;
                    else if (funct[5])      r_state <= S_EXECI;
                    else                    r_state <= S_EXECR;
                end
                S_MEMADR: begin
                    r_state <= r_funct[0] ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    if (mem_ready) r_state <= S_MEMWB;
                end
                S_MEMWRITE: begin
                    if (!r_cond || mem_ready) r_state <= S_FETCH;
                end
                S_EXECR, S_EXECI: begin
                    r_state <= w_nowr ? S_FETCH : S_ALUWB;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        mem_req     = 1'b0;
        alu_control = ALU_W'(ALU_ADD);
        flag_w      = 2'b00;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                illegal   = w_ill;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                imm_src   = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = r_cond & ~w_rd_pc;
                pc_write   = r_cond & w_rd_pc;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                reg_src = 2'b10;
                mem_req = r_cond;
                mem_w   = r_cond;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = w_alu;
                flag_w      = w_flag & {2{r_cond}};
            end
            S_ALUWB: begin
                reg_w    = r_cond & ~w_rd_pc;
                pc_write = r_cond & w_rd_pc;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = r_cond;
            end
            default: ;
        endcase
        // Enables must be quiet for the whole reset window, not just after it
        if (!rst_n) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            reg_w    = 1'b0;
            mem_w    = 1'b0;
            mem_req  = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state_o = STATE_W'(r_state);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multicycle successor to the single-cycle instruction decoder: same op/funct/rd decode, driven by a registered FSM.
- Sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK over several cycles, stalling on a memory ready handshake.
- Adds CMP/TST (flag-only), optional EOR, condition gating and illegal-op detection.
- Sits between the instruction register / condition-check logic and the shared-memory datapath.

Parameters:
- ALU_W, 2, width of alu_control; 3 enables EOR.
- STATE_W, 4, width of the state_o debug port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  2  instruction bits [27:26].
- funct  in  6  instruction bits [25:20].
- rd  in  4  destination register.
- cond_ex  in  1  condition passed, from the condition unit.
- mem_ready  in  1  memory has accepted or returned data this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  instruction register load.
- adr_src  out  1  0 = PC, 1 = ALU result register.
- alu_src_a  out  2  00 = Rn, 01 = PC.
- alu_src_b  out  2  00 = Rm, 01 = extended immediate, 10 = constant 4.
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALU direct.
- imm_src  out  2  immediate extend type.
- reg_src  out  2  register-address select.
- reg_w  out  1  register file write.
- mem_w  out  1  memory write request.
- mem_req  out  1  memory access request.
- alu_control  out  ALU_W  ALU operation.
- flag_w  out  2  [1] = NZ write, [0] = CV write.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- state_o  out  STATE_W  current state.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Reset (async, rst_n=0): state = FETCH. While in reset, all enables (pc_write, ir_write, reg_w, mem_w, mem_req) are 0 and illegal = 0.
- Outputs are a Moore function of state, plus registered decode fields latched in DECODE.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10.
  - Stay while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1 (PC+4), next state DECODE.
- DECODE: alu_src_a=01, alu_src_b=10 (forms PC+8). Latch op/funct/rd/cond_ex decode. Next state:
  - op=01 → MEMADR.
  - op=00 and funct[5]=1 → EXECI.
  - op=00 and funct[5]=0 → EXECR.
  - op=10 → BRANCH.
  - op=11, or an undecodable ALU cmd → FETCH with illegal=1 for that DECODE cycle; no writes.
- ALU command decode, funct[4:1] → alu_control:
  - 0100 ADD → 0.
  - 0010 SUB → 1.
  - 0000 AND → 2.
  - 1100 ORR → 3.
  - 1010 CMP → SUB, no register write.
  - 1000 TST → AND, no register write.
  - 0001 EOR → 4, only when ALU_W=3; otherwise illegal.
- Flag writes:
  - flag_w[1] = funct[0] (forced 1 for CMP/TST).
  - flag_w[0] = flag_w[1] & (ADD | SUB | CMP).
  - Both asserted only in EXECR/EXECI, gated by cond_ex.
- EXECR/EXECI: alu_src_b = 00 or 01 respectively. Next state ALUWB, or FETCH for CMP/TST.
- ALUWB: result_src=00.
  - reg_w = cond_ex & (rd≠15).
  - pc_write = cond_ex & (rd=15).
  - Next state FETCH.
- MEMADR: alu_src_b=01, imm_src=01. Next state MEMREAD if funct[0]=1, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_w = cond_ex & (rd≠15), pc_write = cond_ex & (rd=15). Next state FETCH.
- MEMWRITE:
  - mem_req=1, adr_src=1, reg_src[1]=1, mem_w=cond_ex.
  - If cond_ex=0, skip to FETCH with no request.
  - Otherwise wait for mem_ready, then FETCH.
- BRANCH: alu_src_a=00 (PC-relative base), alu_src_b=01, imm_src=10, result_src=10, pc_write=cond_ex. Next state FETCH.
- Unused outputs are 0 in every state. alu_control = ADD outside the EXEC states.
- Instruction cycle counts with mem_ready already high: ALU reg/imm 4, CMP/TST 3, LDR 5, STR 4, B 3.
- Each mem_ready wait cycle adds exactly 1 to these counts.
- Reset mid-instruction: immediate return to FETCH; no partial write is completed.

Decomposition:
- Package mc_pkg holds:
  - state_t enum.
  - op constants (OP_DP, OP_MEM, OP_BR).
  - ALU cmd constants.
  - ALU control codes.
- Sub-module alu_decoder (combinational, parametrised by ALU_W): funct + op → alu_control, flag_w, no_write, illegal.
- The FSM stays in multicycle_controller.

Test Plan:
- ADD register, funct=001000 (S=0), rd=3, cond_ex=1, mem_ready=1 → visits FETCH, DECODE, EXECR, ALUWB; reg_w=1 in ALUWB; flag_w=00; 4 cycles.
- SUBS immediate, funct=100101, rd=15 → pc_write=1 in ALUWB, reg_w=0; flag_w=11 in EXECI.
- CMP, funct=010101 → FETCH after EXECR; reg_w never asserted; flag_w=11.
- LDR with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; reg_w pulses once in MEMWB.
- STR with cond_ex=0 → mem_w and mem_req never high after MEMADR; returns to FETCH.
- Illegal cases:
  - EOR with ALU_W=2 → illegal pulse in DECODE, no writes.
  - EOR with ALU_W=3 → alu_control=4.
  - rst_n dropped in MEMREAD → state_o=FETCH immediately, all enables 0.
